axilite_cmd_master: RTL and testbench

- Parametrised AXI4-Lite master engine.
- Executes single read/write commands from a valid/ready command port and returns results on a valid/ready response port.
- Successor to the fixed 32-bit debug master:
  - widths are configurable;
  - real WSTRB/RRESP/BRESP handling;
  - per-transaction timeout with error reporting.
- Sits between a debug/config command source (UART, JTAG or sim driver) and the AXI-Lite register interconnect.

---
 rtl/axilite_cmd_master.sv | 192 +++++++++++++++++++
 tb/tb_axilite_cmd_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axilite_cmd_master.sv
// rtl/axilite_cmd_master.sv - single-outstanding AXI4-Lite master driven by a valid/ready command port
// Each command becomes one AXI-Lite read or write; the result, or a timeout, is returned on the response port.
module axilite_cmd_master #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         TIMEOUT    = 1024,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    err_timeout,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]              axi_awprot,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [2:0]              axi_arprot,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rvalid,
  output logic                    axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

  state_t state;
  logic   ready_en;
  logic   in_txn;
  logic   exit_hs;
  logic   tmo_hit;

  // ready_en keeps cmd_ready low until the first edge after reset release
  assign cmd_ready  = ready_en && (state == IDLE);
  assign busy       = (state != IDLE);
  assign axi_awprot = PROT;
  assign axi_arprot = PROT;
  assign in_txn     = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_R);

  // A handshake that leaves the current state takes priority over a timeout in the same cycle
  always_comb begin
    exit_hs = 1'b0;
    case (state)
      WR:      exit_hs = (!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready);
      WR_B:    exit_hs = axi_bvalid;
      RD_A:    exit_hs = axi_arready;
      RD_R:    exit_hs = axi_rvalid;
      default: exit_hs = 1'b0;
    endcase
  end

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int            CW    = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
      logic [CW-1:0] cnt;

      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (cmd_valid && cmd_ready) begin
          cnt <= '0;
        end else if (in_txn && (cnt != TMAX)) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign tmo_hit = in_txn && (cnt == TLAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_en    <= 1'b0;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (tmo_hit && !exit_hs) begin
        axi_awvalid <= 1'b0;
        axi_wvalid  <= 1'b0;
        axi_bready  <= 1'b0;
        axi_arvalid <= 1'b0;
        axi_rready  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_resp    <= 2'b10;
        rsp_timeout <= 1'b1;
        err_timeout <= 1'b1;
        state       <= RSP;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid && cmd_ready) begin
              if (cmd_write) begin
                axi_awaddr  <= cmd_addr;
                axi_wdata   <= cmd_wdata;
                axi_wstrb   <= cmd_wstrb;
                axi_awvalid <= 1'b1;
                axi_wvalid  <= 1'b1;
                state       <= WR;
              end else begin
                axi_araddr  <= cmd_addr;
                axi_arvalid <= 1'b1;
                state       <= RD_A;
              end
            end
          end
          WR: begin
            if (axi_awready) axi_awvalid <= 1'b0;
            if (axi_wready)  axi_wvalid  <= 1'b0;
            if (exit_hs) begin
              axi_bready <= 1'b1;
              state      <= WR_B;
            end
          end
          WR_B: begin
            if (axi_bvalid) begin
              axi_bready  <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_resp    <= axi_bresp;
              rsp_timeout <= 1'b0;
              state       <= RSP;
            end
          end
          RD_A: begin
            if (axi_arready) begin
              axi_arvalid <= 1'b0;
              axi_rready  <= 1'b1;
              state       <= RD_R;
            end
          end
          RD_R: begin
            if (axi_rvalid) begin
              axi_rready  <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_rdata   <= axi_rdata;
              rsp_resp    <= axi_rresp;
              rsp_timeout <= 1'b0;
              state       <= RSP;
            end
          end
          RSP: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axilite_cmd_master.sv
// tb/tb_axilite_cmd_master.sv - directed and randomized bench for axilite_cmd_master
// Expected cycle-by-cycle channel activity is derived from per-transaction slave delays.
module tb_axilite_cmd_master;

  localparam int         AW     = 32;
  localparam int         DW     = 32;
  localparam int         TMO    = 8;
  localparam logic [2:0] PROT_V = 3'b010;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout, err_timeout, busy;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [2:0]    axi_awprot, axi_arprot;
  logic          axi_awvalid, axi_awready = 1'b0;
  logic [DW-1:0] axi_wdata;
  logic [3:0]    axi_wstrb;
  logic          axi_wvalid, axi_wready = 1'b0;
  logic [1:0]    axi_bresp = 2'b00;
  logic          axi_bvalid = 1'b0, axi_bready;
  logic          axi_arvalid, axi_arready = 1'b0;
  logic [DW-1:0] axi_rdata = '0;
  logic [1:0]    axi_rresp = 2'b00;
  logic          axi_rvalid = 1'b0, axi_rready;

  int   n_pass = 0;
  int   n_checks = 0;
  logic err_exp = 1'b0;

  always #5 clock = ~clock;

  axilite_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .PROT(PROT_V)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .err_timeout(err_timeout), .busy(busy),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a/w: cycles before awready/wready (or arready); b/r: extra cycles before bvalid/rvalid; rd: rsp_ready delay
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] sd, input logic [1:0] sresp,
                     input int a, input int w, input int b, input int r, input int rd);
    int m, n_done, n_end;
    logic timed;
    logic [31:0] exp_rdata;
    logic [1:0] exp_resp;
    m         = (a > w) ? a : w;
    n_done    = wr ? (m + 2 + b) : (a + 2 + r);
    timed     = (n_done > TMO);
    n_end     = timed ? TMO : n_done;
    exp_resp  = timed ? 2'b10 : sresp;
    exp_rdata = (timed || wr) ? 32'h0 : sd;
    err_exp   = err_exp | timed;

    check1("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    axi_rdata = sd; axi_rresp = sresp; axi_bresp = sresp;
    for (int k = 0; k <= n_end; k++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      check1("busy", busy, 1'b1);
      check1("cmd_ready_busy", cmd_ready, 1'b0);
      check1("awvalid", axi_awvalid, wr && k <= a && k < n_end);
      check1("wvalid", axi_wvalid, wr && k <= w && k < n_end);
      check1("bready", axi_bready, wr && k >= m + 1 && k < n_end);
      check1("arvalid", axi_arvalid, !wr && k <= a && k < n_end);
      check1("rready", axi_rready, !wr && k >= a + 1 && k < n_end);
      check1("rsp_valid", rsp_valid, k >= n_end);
      if (k == 0 && wr) begin
        checkv("awaddr", 64'(axi_awaddr), 64'(addr));
        checkv("wdata", 64'(axi_wdata), 64'(wdata));
        checkv("wstrb", 64'(axi_wstrb), 64'(strb));
        checkv("awprot", 64'(axi_awprot), 64'(PROT_V));
      end else if (k == 0) begin
        checkv("araddr", 64'(axi_araddr), 64'(addr));
        checkv("arprot", 64'(axi_arprot), 64'(PROT_V));
      end
      axi_awready = wr && k == a && k < n_end;
      axi_wready  = wr && k == w && k < n_end;
      axi_bvalid  = wr && k >= m + 1 + b && k < n_end;
      axi_arready = !wr && k == a && k < n_end;
      axi_rvalid  = !wr && k >= a + 1 + r && k < n_end;
    end
    checkv("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    checkv("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
    check1("rsp_timeout", rsp_timeout, timed);
    check1("err_timeout", err_timeout, err_exp);
    for (int j = 0; j < rd; j++) begin
      @(negedge clock);
      check1("hold_rsp_valid", rsp_valid, 1'b1);
      checkv("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      checkv("hold_rsp_resp", 64'(rsp_resp), 64'(exp_resp));
      check1("hold_rsp_timeout", rsp_timeout, timed);
      check1("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check1("rsp_done_valid", rsp_valid, 1'b0);
    check1("rsp_done_busy", busy, 1'b0);
    check1("rsp_done_cmd_ready", cmd_ready, 1'b1);
    check1("err_timeout_after", err_timeout, err_exp);
  endtask

  initial begin
    #12;
    check1("rst_cmd_ready", cmd_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_awvalid", axi_awvalid, 1'b0);
    check1("rst_arvalid", axi_arvalid, 1'b0);
    check1("rst_err", err_timeout, 1'b0);
    checkv("rst_awaddr", 64'(axi_awaddr), 64'h0);
    @(negedge clock);
    rst_n = 1'b1;
    #1 check1("rel_cmd_ready_before_edge", cmd_ready, 1'b0);
    @(negedge clock);
    check1("rel_cmd_ready_after_edge", cmd_ready, 1'b1);

    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 0, 0, 0, 0, 0);
    txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h1234_5678, 2'b11, 0, 0, 0, 0, 0);
    txn(1'b1, 32'h0000_0030, 32'hA5A5_0F0F, 4'h5, 32'h0, 2'b00, 3, 0, 0, 0, 0);
    txn(1'b1, 32'h0000_0034, 32'h0F0F_A5A5, 4'hA, 32'h0, 2'b00, 0, 3, 0, 0, 0);
    txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 2, 0, 0, 4, 0);
    txn(1'b0, 32'h0000_0048, 32'h0, 4'h0, 32'h5555_AAAA, 2'b10, 0, 0, 0, 1, 0);
    txn(1'b1, 32'h0000_0050, 32'h1111_2222, 4'h3, 32'h0, 2'b01, 1, 1, 3, 0, 5);
    txn(1'b0, 32'h0000_0054, 32'h0, 4'h0, 32'h3333_4444, 2'b00, 0, 0, 0, 0, 0);
    txn(1'b0, 32'h0000_0060, 32'h0, 4'h0, 32'h7777_8888, 2'b00, 20, 0, 0, 0, 2);
    check1("err_sticky", err_timeout, 1'b1);

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
          2'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    check1("err_before_reset", err_timeout, err_exp);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0070; cmd_wdata = 32'h9999_0000; cmd_wstrb = 4'hF;
    @(negedge clock);
    cmd_valid = 1'b0; axi_awready = 1'b1; axi_wready = 1'b1;
    @(negedge clock);
    axi_awready = 1'b0; axi_wready = 1'b0;
    check1("mid_bready", axi_bready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("arst_bready", axi_bready, 1'b0);
    check1("arst_awvalid", axi_awvalid, 1'b0);
    check1("arst_wvalid", axi_wvalid, 1'b0);
    check1("arst_arvalid", axi_arvalid, 1'b0);
    check1("arst_rready", axi_rready, 1'b0);
    check1("arst_rsp_valid", rsp_valid, 1'b0);
    check1("arst_busy", busy, 1'b0);
    check1("arst_cmd_ready", cmd_ready, 1'b0);
    check1("arst_err", err_timeout, 1'b0);
    check1("arst_rsp_timeout", rsp_timeout, 1'b0);
    checkv("arst_rsp_resp", 64'(rsp_resp), 64'h0);
    checkv("arst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    checkv("arst_awaddr", 64'(axi_awaddr), 64'h0);
    checkv("arst_wdata", 64'(axi_wdata), 64'h0);
    err_exp = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    #1 check1("rel2_cmd_ready_before_edge", cmd_ready, 1'b0);
    @(posedge clock);
    #1 check1("rel2_cmd_ready_after_edge", cmd_ready, 1'b1);
    @(negedge clock);
    txn(1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'hBEEF_0001, 2'b00, 1, 0, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
